// File: rtl/joypad_pkg.sv
// Shared types and constants for the joypad / P1 register path.
// Button bit positions, P1 select bit positions and the IRQ state encoding.
package joypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        HOLD
    } irq_state_t;

    localparam int BTN_RIGHT  = 0;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_UP     = 2;
    localparam int BTN_DOWN   = 3;
    localparam int BTN_A      = 4;
    localparam int BTN_B      = 5;
    localparam int BTN_SELECT = 6;
    localparam int BTN_START  = 7;

    localparam int P1_SEL_DIR = 4;
    localparam int P1_SEL_ACT = 5;

    // Active-low matrix nibble; a cleared select bit enables that group.
    function automatic logic [3:0] p1_line(input logic [1:0] sel, input logic [7:0] btn);
        logic [3:0] dir_n;
        logic [3:0] act_n;
        dir_n = ~{btn[BTN_DOWN], btn[BTN_UP], btn[BTN_LEFT], btn[BTN_RIGHT]};
        act_n = ~{btn[BTN_START], btn[BTN_SELECT], btn[BTN_B], btn[BTN_A]};
        return (sel[0] ? 4'hF : dir_n) & (sel[1] ? 4'hF : act_n);
    endfunction

endpackage

// File: rtl/joypad_ctrl_ccounter.sv
// Clear/increment counter used for the post-ack interrupt holdoff.
// Latency: count updates on the edge after clr/inc; clr has priority; no backpressure.
module joypad_ctrl_ccounter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/joypad_ctrl.sv
// P1/JOYP register view of 8 debounced buttons plus joypad IRQ and STOP wake level.
// Latency: button or P1 write -> rd_data 1 cycle (buttons 3 cycles with JOYPAD_SYNC_EN).
// Backpressure: none; inputs sampled every cycle, irq held until irq_ack.
module joypad_ctrl
    import joypad_pkg::*;
#(
    parameter int HOLDOFF = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] buttons,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic [7:0] rd_data,
    output logic       irq,
    input  logic       irq_ack,
    output logic       wake
);

    localparam int CW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam logic [CW-1:0] HOLD_LAST = (HOLDOFF < 1) ? '0 : CW'(HOLDOFF - 1);

    logic [1:0]    sel_q;
    logic [3:0]    line_q;
    logic [3:0]    line_prev;
    logic [7:0]    btn_use;
    logic          fall;
    irq_state_t    state;
    irq_state_t    state_nx;
    logic          cnt_clr;
    logic          cnt_inc;
    logic [CW-1:0] cnt;
    logic          unused_din;

    assign unused_din = ^{din[7:6], din[3:0]};

`ifdef JOYPAD_SYNC_EN
    logic [7:0] btn_s1;
    logic [7:0] btn_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_s1 <= 8'h00;
            btn_s2 <= 8'h00;
        end else begin
            btn_s1 <= buttons;
            btn_s2 <= btn_s1;
        end
    end

    assign btn_use = btn_s2;
`else
    assign btn_use = buttons;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q     <= 2'b11;
            line_q    <= 4'hF;
            line_prev <= 4'hF;
        end else begin
            if (wr_en) begin
                sel_q <= din[P1_SEL_ACT:P1_SEL_DIR];
            end
            line_q    <= p1_line(sel_q, btn_use);
            line_prev <= line_q;
        end
    end

    assign rd_data = {2'b11, sel_q, line_q};
    assign wake    = ~&line_q;
    // Selection changes that pull a line low count as presses too.
    assign fall    = |(line_prev & ~line_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nx = PEND;
                end
            end
            PEND: begin
                // Ack beats a coincident fall; that fall is dropped.
                if (irq_ack) begin
                    cnt_clr  = 1'b1;
                    state_nx = (HOLDOFF == 0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                cnt_inc = 1'b1;
                if (cnt == HOLD_LAST) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign irq = (state == PEND);

    joypad_ctrl_ccounter #(
        .WIDTH(CW)
    ) u_holdoff_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .count(cnt)
    );

endmodule

// File: tb/tb_joypad_ctrl.sv
// Directed, table-driven bench for joypad_ctrl (HOLDOFF=16); JOYPAD_SYNC_EN selects the synchronizer checks.
module tb_joypad_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] buttons;
    logic       wr_en;
    logic [7:0] din;
    logic [7:0] rd_data;
    logic       irq;
    logic       irq_ack;
    logic       wake;

    int n_chk;
    int n_fail;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic [7:0] btn;
        logic       ack;
        logic [7:0] rd;
        logic       irq;
        logic       wake;
    } vec_t;

    vec_t vecs[$];

    joypad_ctrl #(.HOLDOFF(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .buttons(buttons),
        .wr_en  (wr_en),
        .din    (din),
        .rd_data(rd_data),
        .irq    (irq),
        .irq_ack(irq_ack),
        .wake   (wake)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [7:0] d, input logic [7:0] b, input logic a,
                       input logic [7:0] rd, input logic iq, input logic wk);
        vec_t v;
        v.wr = wr; v.din = d; v.btn = b; v.ack = a;
        v.rd = rd; v.irq = iq; v.wake = wk;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        reset   = 1'b1;
        buttons = 8'hFF;
        wr_en   = 1'b0;
        din     = 8'h00;
        irq_ack = 1'b0;
        #1;
        chk("reset rd", rd_data, 8'hFF);
        chk("reset irq", {7'd0, irq}, 8'h00);
        chk("reset wake", {7'd0, wake}, 8'h00);
        repeat (3) step();
        reset = 1'b0;

`ifndef JOYPAD_SYNC_EN
        // Direction group, right press, irq, ack and holdoff window boundaries
        add(1, 8'h20, 8'h00, 0, 8'hEF, 0, 0);
        add(0, 8'h00, 8'h01, 0, 8'hEE, 0, 1);
        add(0, 8'h00, 8'h01, 0, 8'hEE, 1, 1);
        add(0, 8'h00, 8'h01, 1, 8'hEE, 0, 1);
        for (int k = 0; k < 4; k++) add(0, 8'h00, 8'h01, 0, 8'hEE, 0, 1);
        add(0, 8'h00, 8'h05, 0, 8'hEA, 0, 1);
        add(0, 8'h00, 8'h05, 0, 8'hEA, 0, 1);
        for (int k = 0; k < 8; k++) add(0, 8'h00, 8'h00, 0, 8'hEF, 0, 0);
        add(0, 8'h00, 8'h04, 0, 8'hEB, 0, 1);
        add(0, 8'h00, 8'h00, 0, 8'hEF, 0, 0);
        add(0, 8'h00, 8'h04, 0, 8'hEB, 0, 1);
        add(0, 8'h00, 8'h04, 0, 8'hEB, 1, 1);
        // Both groups selected, a+left held: nibble D & E = C
        add(1, 8'h00, 8'h12, 1, 8'hCD, 0, 1);
        for (int k = 0; k < 14; k++) add(0, 8'h00, 8'h12, 0, 8'hCC, 0, 1);
        add(0, 8'h00, 8'h10, 0, 8'hCE, 0, 1);
        add(0, 8'h00, 8'h12, 0, 8'hCC, 0, 1);
        add(0, 8'h00, 8'h12, 0, 8'hCC, 1, 1);
        add(0, 8'h00, 8'h12, 1, 8'hCC, 0, 1);
        for (int k = 0; k < 16; k++) add(0, 8'h00, 8'h12, 0, 8'hCC, 0, 1);
        // Selection change lowers a line, then ack coincident with a new fall
        add(1, 8'h20, 8'h10, 0, 8'hEE, 0, 1);
        add(0, 8'h00, 8'h10, 0, 8'hEF, 0, 0);
        add(0, 8'h00, 8'h10, 0, 8'hEF, 0, 0);
        add(1, 8'h10, 8'h10, 0, 8'hDF, 0, 0);
        add(0, 8'h00, 8'h10, 0, 8'hDE, 0, 1);
        add(0, 8'h00, 8'h10, 0, 8'hDE, 1, 1);
        add(0, 8'h00, 8'h30, 0, 8'hDC, 1, 1);
        add(0, 8'h00, 8'h30, 1, 8'hDC, 0, 1);
        add(0, 8'h00, 8'h30, 0, 8'hDC, 0, 1);
        add(0, 8'h00, 8'h30, 0, 8'hDC, 0, 1);

        foreach (vecs[i]) begin
            wr_en   = vecs[i].wr;
            din     = vecs[i].din;
            buttons = vecs[i].btn;
            irq_ack = vecs[i].ack;
            step();
            chk($sformatf("v%0d rd", i), rd_data, vecs[i].rd);
            chk($sformatf("v%0d irq", i), {7'd0, irq}, {7'd0, vecs[i].irq});
            chk($sformatf("v%0d wake", i), {7'd0, wake}, {7'd0, vecs[i].wake});
        end
        wr_en   = 1'b0;
        irq_ack = 1'b0;

        // Let the holdoff expire, raise a fresh irq, then reset in PEND
        repeat (20) step();
        buttons = 8'hB0;
        step();
        chk("pend rd", rd_data, 8'hD4);
        chk("pend irq early", {7'd0, irq}, 8'h00);
        step();
        chk("pend irq", {7'd0, irq}, 8'h01);
        #3;
        reset = 1'b1;
        #1;
        chk("async rst irq", {7'd0, irq}, 8'h00);
        chk("async rst rd", rd_data, 8'hFF);
        chk("async rst wake", {7'd0, wake}, 8'h00);
        step();
        reset = 1'b0;
        step();
        chk("post rst rd", rd_data, 8'hFF);
        chk("post rst irq", {7'd0, irq}, 8'h00);
`else
        wr_en   = 1'b1;
        din     = 8'h20;
        buttons = 8'h00;
        step();
        wr_en = 1'b0;
        chk("sync wr rd", rd_data, 8'hEF);
        repeat (3) step();
        chk("sync idle rd", rd_data, 8'hEF);
        buttons = 8'h01;
        step();
        chk("sync lat1 rd", rd_data, 8'hEF);
        step();
        chk("sync lat2 rd", rd_data, 8'hEF);
        chk("sync lat2 wake", {7'd0, wake}, 8'h00);
        step();
        chk("sync lat3 rd", rd_data, 8'hEE);
        chk("sync lat3 wake", {7'd0, wake}, 8'h01);
        chk("sync lat3 irq", {7'd0, irq}, 8'h00);
        step();
        chk("sync irq", {7'd0, irq}, 8'h01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
